// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for a 5-stage MIPS core: load-use stalls,
// branch squashes, data-memory freezes, halt/drain/resume and perf counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic load_use;
  logic freeze;
  logic flush_act;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  assign freeze   = mem_busy && (state_q != HALTED);

  // Mealy output decode; the priority order matters (freeze beats branch beats drain/load-use).
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    halted       = 1'b0;
    flush_act    = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      halted       = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_act    = 1'b1;
    end else if (state_q == DRAIN || load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (halt_req && !freeze) begin
          state_d     = DRAIN;
          drain_cnt_d = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!freeze) begin
          drain_cnt_d = drain_cnt_q - 4'd1;
          if (drain_cnt_q == 4'd1) state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume_req && !halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && (state_q != HALTED) && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_act && !(&flush_count_q))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      drain_cnt_q    <= 4'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Each cycle it generates the PC, IF/ID, ID/EX and EX/MEM write-enable, flush and bubble controls.
- It handles load-use stalls, taken-branch squashes, data-memory wait freezes, and a halt/drain/resume sequence.
- It keeps stall and flush performance counters.
- It sits beside the ID/EX register and drives its bubble (zero all control fields) and hold inputs.

Parameters:
DRAIN_CYCLES, 3, number of unfrozen bubble cycles inserted after halt acceptance before HALTED (empties EX/MEM/WB); legal range 1..15
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  ID/EX mem_read (load in EX)
ex_rt  in  5  ID/EX rt (load destination)
branch_taken  in  1  branch/jump in EX resolved taken (level, must hold while frozen)
mem_busy  in  1  data memory not ready this cycle
halt_req  in  1  level request to halt
resume_req  in  1  level request to leave HALTED
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX loads zeroed control fields
ex_mem_write  out  1  EX/MEM and MEM/WB load enable
halted  out  1  state == HALTED
stall_cycles  out  CNT_W  performance counter
flush_count  out  CNT_W  performance counter

Behaviour:
- Synchronous reset, active-high on clk:
  - state <= RUN; drain counter <= 0; both performance counters <= 0.
  - While reset is high, outputs are forced to: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1, halted=0.
  - A reset in any state, including mid-drain, returns to RUN the next cycle.
- Derived terms:
  - load_use = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
  - freeze = mem_busy & (state!=HALTED).
- Outputs are combinational from state and inputs; zero-latency Mealy. Priority in RUN and DRAIN, highest first:
  1. freeze: all write enables = 0; flush = 0; bubble = 0. The whole pipeline holds, the drain counter holds, and branch_taken and load_use are ignored.
  2. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1. Exactly two younger instructions are squashed.
  3. state==DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1. IF and ID hold their instructions, and older stages advance.
  4. load_use (RUN only): pc_write=0, if_id_write=0, id_ex_bubble=1. This is a single bubble; on the next cycle ex_mem_read is 0, so the stall clears.
  5. default: all enables 1; flush = 0; bubble = 0.
- id_ex_write = ex_mem_write = !freeze in RUN and DRAIN.
- HALTED outputs: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1, halted=1. mem_busy is ignored.
- State transitions (evaluated at posedge):
  - RUN -> DRAIN when halt_req & !freeze; the drain counter loads DRAIN_CYCLES. Outputs in that acceptance cycle still follow the RUN priority; a branch or load-use in that cycle is fully serviced.
  - DRAIN: when !freeze, the counter decrements; when the counter==1 & !freeze, go to HALTED. DRAIN therefore lasts exactly DRAIN_CYCLES unfrozen cycles. halt_req deassertion during DRAIN does not abort the drain.
  - HALTED -> RUN when resume_req & !halt_req. With both high, stay in HALTED.
- Counters:
  - stall_cycles += 1 each non-reset cycle where pc_write==0 and state!=HALTED (covers freeze, load-use and drain).
  - flush_count += 1 each cycle where the branch_taken action (priority 2) is taken.
  - Both counters saturate at all-ones; no wrap.

Test Plan:
- Load-use: lw $t0 in EX (ex_mem_read=1, ex_rt=8) with ID add reading rs=8 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle with ex_mem_read=0, all enables are 1; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- Branch: branch_taken=1 with load_use also true -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; no load-use stall.
- Freeze: mem_busy=1 for 3 cycles with branch_taken=1 -> all enables 0 for 3 cycles and no flush; on the 4th cycle the flush fires; stall_cycles=3.
- Halt drain: halt_req pulse at cycle N, DRAIN_CYCLES=3 -> DRAIN during N+1..N+3 with bubble=1 and pc_write=0; halted=1 from N+4. A mem_busy=1 cycle inserted mid-drain extends HALTED entry by one cycle.
- Resume: HALTED with resume_req=1 & halt_req=1 -> stays HALTED. After dropping halt_req -> RUN next cycle, all enables 1.
- Reset mid-DRAIN: assert reset for 1 cycle -> state RUN, counters 0, halted=0; during the reset cycle id_ex_bubble=1 and pc_write=0.
